sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
Sequencer for the SAR ADC macro instantiated inside adc_wrapper. It handles channel selection, sample timing, the bitwise successive approximation that drives the capacitive DAC code, and result hand-off.
- Channels are scanned round-robin across an enable mask, in single-shot or continuous mode.
- Results are held for the Wishbone register file, which sits outside this block.
- Results also raise an interrupt line.

Parameters:
NBITS, 10, conversion resolution in bits (>=2)
NCH, 8, number of analog mux channels (>=2)
CH_W, $clog2(NCH), channel index width

Ports:
wb_clk_i  in  1  system clock
wb_rst_ni  in  1  reset, synchronous, active-low
en_i  in  1  block enable; low aborts any conversion
start_i  in  1  single-shot request, 1-cycle pulse
cont_i  in  1  continuous mode: rescan back-to-back while high
ch_mask_i  in  NCH  channels eligible for scan
clkdiv_i  in  8  conversion tick every clkdiv_i+1 clocks
sample_cyc_i  in  4  sample phase length in ticks (0 treated as 1)
cmp_i  in  1  comparator output, 1 = Vin >= Vdac; settled and valid at each tick
data_rd_i  in  1  register file consumed result, 1-cycle pulse
sample_o  out  1  sample switch closed
dac_code_o  out  NBITS  trial code to the DAC
ch_sel_o  out  CH_W  analog mux select
busy_o  out  1  state != IDLE
data_o  out  NBITS  last result
data_ch_o  out  CH_W  channel of last result
data_valid_o  out  1  result held, not yet read
overrun_o  out  1  sticky: a result was overwritten unread; cleared by data_rd_i
irq_o  out  1  equals data_valid_o

Behaviour:
- Reset (wb_rst_ni=0 at an edge): every output 0, state IDLE, round-robin pointer 0, tick counter 0.
- Tick: the counter clears on every state entry and counts 0..clkdiv_i. A tick occurs when count==clkdiv_i, then the counter wraps to 0.
- IDLE:
  - Leave when en_i & (start_i | cont_i) & |ch_mask_i.
  - Select the lowest-index enabled channel >= pointer, wrapping modulo NCH.
  - Next cycle: ch_sel_o = selected channel, sample_o=1, state SAMPLE.
  - start_i while not IDLE is ignored, not queued. An all-zero mask never starts.
- SAMPLE:
  - Lasts max(sample_cyc_i,1) ticks.
  - On the last tick: sample_o=0, dac_code_o = 1<<(NBITS-1), bit index = NBITS-1, state CONV.
- CONV, on each tick:
  - Bit[idx] of dac_code_o is kept if cmp_i=1, else cleared.
  - If idx>0: set bit[idx-1] and decrement idx.
  - If idx==0: state DONE.
- DONE, single cycle:
  - data_o = dac_code_o, data_ch_o = ch_sel_o, data_valid_o=1.
  - overrun_o set if data_valid_o was already 1 and data_rd_i is not asserted this cycle.
  - Pointer = (ch_sel_o+1) mod NCH, dac_code_o=0, state IDLE.
- Latency, with start sampled at edge 1: data_valid_o high from cycle 2 + (S+NBITS)*(clkdiv_i+1), where S = max(sample_cyc_i,1). For NBITS=10, D=0, S=1 this is cycle 13.
- Continuous mode: IDLE re-launches on the cycle after DONE. Conversion period = 2 + (S+NBITS)*(D+1).
- data_rd_i clears data_valid_o and overrun_o. If DONE and data_rd_i coincide, the new result wins: data_valid_o stays 1, overrun_o is not set.
- en_i low in any non-IDLE state aborts on the next edge:
  - sample_o=0, dac_code_o=0, state IDLE.
  - No result, data registers unchanged, pointer unchanged.
- clkdiv_i, sample_cyc_i and ch_mask_i are sampled continuously. Software changes them only while busy_o=0; mid-conversion changes take effect at the next tick compare.

Decomposition:
- Package sar_adc_pkg holds:
  - the state enum (IDLE, SAMPLE, CONV, DONE);
  - default NBITS/NCH;
  - the CH_W derivation;
  - a function next_ch(mask, ptr) for the round-robin pick.
- One sub-module, sar_tick_gen: divider counter with clear input and tick output.

Test Plan:
- Comparator model (vin >= dac_code_o), vin=0x2A5, ch_mask=0x01, D=0, S=1, start pulse → data_o=0x2A5, data_ch_o=0, data_valid_o/irq_o rise exactly 13 cycles after start, busy_o low the same cycle.
- vin=0x3FF then vin=0x000 → data_o=0x3FF and 0x000; dac_code_o trace 0x200,0x300,... and 0x200,0x100,0x080,... respectively.
- cont_i=1, ch_mask=8'b1010_0001, D=3, S=2 → data_ch_o sequence 0,5,7,0,5; period 2+12*4=50 cycles; no data_rd_i → overrun_o set at the 2nd result; data_rd_i pulse clears both flags.
- en_i dropped mid-CONV (bit 6) → next cycle busy_o=0, dac_code_o=0, data_o unchanged, no irq; following start converts the same channel.
- start_i while busy, and start_i with ch_mask=0 → both ignored, no extra result. wb_rst_ni low mid-SAMPLE → all outputs 0 at the next edge.
- data_rd_i coincident with DONE while data_valid_o=1 → data_valid_o stays 1 with the new data, overrun_o stays 0.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared types, defaults and helpers for the SAR ADC sequencer.
package sar_adc_pkg;

  localparam int unsigned NBITS_DEF = 10;
  localparam int unsigned NCH_DEF   = 8;

  // Widest channel mask the round-robin helper handles.
  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned MAX_CH_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StConv,
    StDone
  } sar_state_e;

  // Channel index width; never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Lowest enabled channel at or above ptr, wrapping modulo nch.
  // Returns ptr when no channel is enabled; callers gate on |mask.
  function automatic int unsigned next_ch(input logic [MAX_CH-1:0] mask,
                                          input int unsigned       ptr,
                                          input int unsigned       nch);
    int unsigned pick;
    int unsigned c;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      c = ptr + i;
      if (c >= nch) begin
        c = c - nch;
      end
      if (i < nch && !found) begin
        if (mask[c[MAX_CH_W-1:0]]) begin
          pick  = c;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sar_tick_gen.sv
// Conversion tick divider: one tick every div_i+1 clocks, restartable via clr_i.
module sar_tick_gen #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Divider is compared live, so a new div_i applies at the next compare.
  assign tick_o = (cnt_q == div_i);

  // Next count: restart on clear or on tick, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC sequencer: round-robin channel pick, sample phase, bitwise
// successive approximation and result hand-off to the register file.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned CH_W  = ch_width(NCH)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic [NCH-1:0]   ch_mask_i,
  input  logic [7:0]       clkdiv_i,
  input  logic [3:0]       sample_cyc_i,
  input  logic             cmp_i,
  input  logic             data_rd_i,
  output logic             sample_o,
  output logic [NBITS-1:0] dac_code_o,
  output logic [CH_W-1:0]  ch_sel_o,
  output logic             busy_o,
  output logic [NBITS-1:0] data_o,
  output logic [CH_W-1:0]  data_ch_o,
  output logic             data_valid_o,
  output logic             overrun_o,
  output logic             irq_o
);

  localparam int unsigned IDX_W = $clog2(NBITS);

  sar_state_e       state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       scnt_q, scnt_d;
  logic             sample_q, sample_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [CH_W-1:0]  dch_q, dch_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             tick;
  logic             tick_clr;
  logic [3:0]       samp_last;

  // Divider restarts on every state entry and stays parked while idle.
  assign tick_clr = (state_q == StIdle) || (state_d != state_q);

  sar_tick_gen #(
    .W (8)
  ) u_tick_gen (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .clr_i  (tick_clr),
    .div_i  (clkdiv_i),
    .tick_o (tick)
  );

  // A programmed sample length of zero behaves as one tick.
  assign samp_last = (sample_cyc_i == 4'd0) ? 4'd0 : sample_cyc_i - 4'd1;

  // Next-state, conversion datapath and result hand-off.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    scnt_d   = scnt_q;
    sample_d = sample_q;
    dac_d    = dac_q;
    ch_d     = ch_q;
    data_d   = data_q;
    dch_d    = dch_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    if (data_rd_i) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (state_q != StIdle && !en_i) begin
      // Abort: drop the conversion, keep result registers and pointer.
      sample_d = 1'b0;
      dac_d    = '0;
      state_d  = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en_i && (start_i || cont_i) && (|ch_mask_i)) begin
            ch_d     = CH_W'(next_ch(MAX_CH'(ch_mask_i), 32'(ptr_q), NCH));
            sample_d = 1'b1;
            scnt_d   = '0;
            state_d  = StSample;
          end
        end
        StSample: begin
          if (tick) begin
            if (scnt_q == samp_last) begin
              sample_d         = 1'b0;
              dac_d            = '0;
              dac_d[NBITS-1]   = 1'b1;
              idx_d            = IDX_W'(NBITS - 1);
              state_d          = StConv;
            end else begin
              scnt_d = scnt_q + 4'd1;
            end
          end
        end
        StConv: begin
          if (tick) begin
            // Keep the trial bit only if Vin is at or above the DAC level.
            dac_d[idx_q] = cmp_i;
            if (idx_q != '0) begin
              dac_d[idx_q - 1'b1] = 1'b1;
              idx_d               = idx_q - 1'b1;
            end else begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          data_d  = dac_q;
          dch_d   = ch_q;
          valid_d = 1'b1;
          // A coincident read consumes the old result, so no overrun.
          ovr_d   = data_rd_i ? 1'b0 : (ovr_q | valid_q);
          ptr_d   = (ch_q == CH_W'(NCH - 1)) ? '0 : ch_q + 1'b1;
          dac_d   = '0;
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      idx_q    <= '0;
      scnt_q   <= '0;
      sample_q <= 1'b0;
      dac_q    <= '0;
      ch_q     <= '0;
      data_q   <= '0;
      dch_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      scnt_q   <= scnt_d;
      sample_q <= sample_d;
      dac_q    <= dac_d;
      ch_q     <= ch_d;
      data_q   <= data_d;
      dch_q    <= dch_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sample_o     = sample_q;
  assign dac_code_o   = dac_q;
  assign ch_sel_o     = ch_q;
  assign busy_o       = (state_q != StIdle);
  assign data_o       = data_q;
  assign data_ch_o    = dch_q;
  assign data_valid_o = valid_q;
  assign overrun_o    = ovr_q;
  assign irq_o        = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl with an ideal comparator (vin >= dac).
module tb_sar_adc_ctrl;

  localparam int NB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [7:0] clkdiv = 8'h00;
  logic [3:0] scyc = 4'd1;
  logic       rd = 1'b0;
  logic       cmp;
  logic [9:0] vin = 10'h000;

  logic       sample;
  logic [9:0] dac;
  logic [2:0] ch_sel;
  logic       busy;
  logic [9:0] data;
  logic [2:0] data_ch;
  logic       valid;
  logic       ovr;
  logic       irq;

  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;

  typedef struct {
    logic [9:0] data;
    logic [2:0] ch;
    logic       ovr;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] trace[$];

  logic [9:0] t_hi[10] = '{10'h200, 10'h300, 10'h380, 10'h3C0, 10'h3E0,
                           10'h3F0, 10'h3F8, 10'h3FC, 10'h3FE, 10'h3FF};
  logic [9:0] t_lo[11] = '{10'h200, 10'h100, 10'h080, 10'h040, 10'h020, 10'h010,
                           10'h008, 10'h004, 10'h002, 10'h001, 10'h000};
  logic [2:0] seq[5] = '{3'd0, 3'd5, 3'd7, 3'd0, 3'd5};

  assign cmp = (vin >= dac);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sar_adc_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .en_i         (en),
    .start_i      (start),
    .cont_i       (cont),
    .ch_mask_i    (mask),
    .clkdiv_i     (clkdiv),
    .sample_cyc_i (scyc),
    .cmp_i        (cmp),
    .data_rd_i    (rd),
    .sample_o     (sample),
    .dac_code_o   (dac),
    .ch_sel_o     (ch_sel),
    .busy_o       (busy),
    .data_o       (data),
    .data_ch_o    (data_ch),
    .data_valid_o (valid),
    .overrun_o    (ovr),
    .irq_o        (irq)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [9:0] v, input logic [2:0] ch, input logic o,
                        input int s, input int d);
    exp_t e;
    e.data = v;
    e.ch   = ch;
    e.ovr  = o;
    e.cyc  = cyc + 2 + (s + NB) * (d + 1);
    sb.push_back(e);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    check("result_wait", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic read_pulse();
    rd = 1'b1;
    step(1);
    rd = 1'b0;
  endtask

  // Dedicated trace of DAC codes during the approximation phase.
  always @(negedge clk) begin
    if (busy && !sample && (trace.size() == 0 || trace[$] != dac)) trace.push_back(dac);
  end

  // Monitor: a completed conversion shows as busy falling with en and reset inactive.
  initial begin : monitor
    logic prev_busy;
    logic en_last;
    logic rst_last;
    exp_t e;
    prev_busy = 1'b0;
    en_last   = 1'b0;
    rst_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !busy && en_last && rst_last) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(data_ch), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("data", 32'(data), 32'(e.data));
          check("data_ch", 32'(data_ch), 32'(e.ch));
          check("valid_irq", 32'({valid, irq}), 32'h3);
          check("overrun", 32'(ovr), 32'(e.ovr));
          check("latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_busy = busy;
      en_last   = en;
      rst_last  = rst_n;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int tgt;
    int base;
    exp_t e;

    step(3);
    check("reset_outputs",
          32'({sample, dac, ch_sel, busy, data, data_ch, valid, ovr, irq}), 32'd0);
    rst_n  = 1'b1;
    en     = 1'b1;
    mask   = 8'h01;
    clkdiv = 8'd0;
    scyc   = 4'd1;
    step(2);

    // Basic conversion and exact latency.
    vin = 10'h2A5;
    launch(10'h2A5, 3'd0, 1'b0, 1, 0);
    wait_empty(40);
    read_pulse();
    check("rd_clears_valid", 32'({valid, irq, ovr}), 32'd0);

    // Full-scale and zero-scale with DAC code traces.
    vin = 10'h3FF;
    trace.delete();
    launch(10'h3FF, 3'd0, 1'b0, 1, 0);
    wait_empty(40);
    check("trace_len_3ff", 32'(trace.size()), 32'd10);
    for (int i = 0; i < 10; i++) check("trace_3ff", 32'(trace[i]), 32'(t_hi[i]));
    read_pulse();

    vin = 10'h000;
    trace.delete();
    launch(10'h000, 3'd0, 1'b0, 1, 0);
    wait_empty(40);
    check("trace_len_000", 32'(trace.size()), 32'd11);
    for (int i = 0; i < 11; i++) check("trace_000", 32'(trace[i]), 32'(t_lo[i]));
    read_pulse();

    // Start while busy is dropped, and an empty mask never starts.
    vin = 10'h0C3;
    launch(10'h0C3, 3'd0, 1'b0, 1, 0);
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_empty(40);
    step(20);
    check("no_queued_start", 32'(busy), 32'd0);
    mask  = 8'h00;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("mask0_no_start", 32'(busy), 32'd0);
    step(20);
    check("mask0_still_idle", 32'({busy, valid, data}), 32'({1'b0, 1'b1, 10'h0C3}));
    mask = 8'h01;

    // Read coincident with DONE while a result is still held.
    vin = 10'h1E7;
    launch(10'h1E7, 3'd0, 1'b0, 1, 0);
    e   = sb[$];
    tgt = e.cyc - 1;
    while (cyc < tgt) step(1);
    rd = 1'b1;
    step(1);
    rd = 1'b0;
    wait_empty(20);

    // Reset in the middle of the sample phase.
    clkdiv = 8'd3;
    scyc   = 4'd2;
    start  = 1'b1;
    step(1);
    start  = 1'b0;
    step(3);
    check("busy_in_sample", 32'({busy, sample}), 32'h3);
    rst_n = 1'b0;
    step(1);
    check("reset_mid_sample",
          32'({sample, dac, ch_sel, busy, data, data_ch, valid, ovr, irq}), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Continuous scan over channels 0, 5, 7 with D=3, S=2.
    vin  = 10'h155;
    mask = 8'b1010_0001;
    base = cyc;
    for (int k = 0; k < 5; k++) begin
      e.data = 10'h155;
      e.ch   = seq[k];
      e.ovr  = (k > 0);
      e.cyc  = base + 50 + 50 * k;
      sb.push_back(e);
    end
    cont = 1'b1;
    step(210);
    cont = 1'b0;
    wait_empty(80);
    step(60);
    check("cont_flags", 32'({valid, ovr, irq}), 32'h7);
    read_pulse();
    check("rd_clears_flags", 32'({valid, ovr, irq}), 32'd0);

    // Abort mid-conversion at bit 6; pointer must stay put.
    clkdiv = 8'd0;
    scyc   = 4'd1;
    mask   = 8'h24;
    vin    = 10'h300;
    start  = 1'b1;
    step(1);
    start  = 1'b0;
    step(4);
    check("dac_at_bit6", 32'(dac), 32'h340);
    en = 1'b0;
    step(1);
    check("abort_state", 32'({busy, sample, dac, irq, valid}), 32'd0);
    check("abort_data_kept", 32'({data, data_ch}), 32'({10'h155, 3'd5}));
    en = 1'b1;
    step(1);
    launch(10'h300, 3'd2, 1'b0, 1, 0);
    wait_empty(40);
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
